// File: rtl/hex_stream_pkg.sv
// Shared types and constants for the hex word streamer.
//   hs_state_t      : streamer FSM states
//   ASCII_*         : control / separator characters
//   nibble_to_ascii : one 4-bit value to its lowercase hex character
package hex_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND3,
    ST_SEND2,
    ST_SEND1,
    ST_SEND0,
    ST_SEP,
    ST_CR,
    ST_LF
  } hs_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // 0..9 map to '0'..'9' (0x30..); 10..15 map to 'a'..'f' (0x61 - 10 = 0x57).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/hex_word_streamer_if.sv
// Word-in / character-out bus of the hex word streamer.
// Signal prefixes are from the streamer's point of view.
//   i_word, i_word_valid, o_word_ready : word producer handshake
//   i_flush                            : one-cycle request to end a partial line
//   o_char, o_char_valid, i_char_ready : byte stream toward the transmit FIFO
//   o_busy                             : streamer not idle or flush pending
// Modports: slave = the streamer, master = producer/consumer side.
interface hex_word_streamer_if;
  logic [15:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;
  logic        i_flush;
  logic [7:0]  o_char;
  logic        o_char_valid;
  logic        i_char_ready;
  logic        o_busy;

  modport slave (
    input  i_word, i_word_valid, i_flush, i_char_ready,
    output o_word_ready, o_char, o_char_valid, o_busy
  );

  modport master (
    output i_word, i_word_valid, i_flush, i_char_ready,
    input  o_word_ready, o_char, o_char_valid, o_busy
  );
endinterface

// File: rtl/bin2ascii.sv
// Registered 16-bit binary to 4-character lowercase hex converter.
// One cycle latency; O_HEX[31:24] holds the character for I_BIN[15:12].
//   I_CLK  : clock
//   I_RSTF : asynchronous active-low reset
//   I_BIN  : binary word
//   O_HEX  : four ASCII characters, most significant nibble in the top byte
module bin2ascii
  import hex_stream_pkg::*;
(
  input  logic        I_CLK,
  input  logic        I_RSTF,
  input  logic [15:0] I_BIN,
  output logic [31:0] O_HEX
);

  logic [31:0] w_hex;
  logic [31:0] r_hex;

  assign w_hex = {nibble_to_ascii(I_BIN[15:12]), nibble_to_ascii(I_BIN[11:8]),
                  nibble_to_ascii(I_BIN[7:4]),   nibble_to_ascii(I_BIN[3:0])};

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) r_hex <= '0;
    else         r_hex <= w_hex;
  end

  assign O_HEX = r_hex;

endmodule

// File: rtl/hex_word_streamer.sv
// Serialises 16-bit words as lowercase hex text: four characters per word,
// then SEPARATOR, or CR LF when the line holds WORDS_PER_LINE words or a
// flush ends a partial line.
//   I_CLK  : clock
//   I_RSTF : asynchronous active-low reset
//   bus    : word handshake, flush request, character stream, busy flag
module hex_word_streamer
  import hex_stream_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter logic [7:0]  SEPARATOR      = ASCII_SP
) (
  input  logic               I_CLK,
  input  logic               I_RSTF,
  hex_word_streamer_if.slave bus
);

  // Index of the last word on a line; line_cnt never goes past it.
  localparam logic [7:0] LAST_IDX = 8'(WORDS_PER_LINE - 1);

  hs_state_t   r_state,      w_state_nxt;
  logic [7:0]  r_line_cnt,   w_line_cnt_nxt;
  logic        r_flush_pend, w_flush_pend_nxt;
  logic [15:0] r_word_q,     w_word_q_nxt;

  logic [31:0] w_hex;
  logic        w_char_valid;
  logic [7:0]  w_char;
  logic        w_hs;
  logic        w_flush_now;

  bin2ascii u_conv (
    .I_CLK (I_CLK),
    .I_RSTF(I_RSTF),
    .I_BIN (r_word_q),
    .O_HEX (w_hex)
  );

  // Character mux: a function of registered state and converter output only,
  // so i_char_ready never reaches an output combinationally.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_char_valid = 1'b0;
    w_char       = 8'h00;
    case (r_state)
      ST_SEND3: begin w_char_valid = 1'b1; w_char = w_hex[31:24]; end
      ST_SEND2: begin w_char_valid = 1'b1; w_char = w_hex[23:16]; end
      ST_SEND1: begin w_char_valid = 1'b1; w_char = w_hex[15:8];  end
      ST_SEND0: begin w_char_valid = 1'b1; w_char = w_hex[7:0];   end
      ST_SEP:   begin w_char_valid = 1'b1; w_char = SEPARATOR;    end
      ST_CR:    begin w_char_valid = 1'b1; w_char = ASCII_CR;     end
      ST_LF:    begin w_char_valid = 1'b1; w_char = ASCII_LF;     end
      default:  ;
    endcase
  end

  assign w_hs = w_char_valid && bus.i_char_ready;

  // A fresh flush in IDLE is serviced at once unless a word arrives with it;
  // in that case the word goes first and the flush waits in flush_pend.
  assign w_flush_now = r_flush_pend || (bus.i_flush && !bus.i_word_valid);

  always_comb begin
    w_state_nxt      = r_state;
    w_line_cnt_nxt   = r_line_cnt;
    w_flush_pend_nxt = r_flush_pend || bus.i_flush;
    w_word_q_nxt     = r_word_q;

    case (r_state)
      ST_IDLE: begin
        if (w_flush_now) begin
          // An empty line needs no CR LF; the request is simply dropped.
          w_flush_pend_nxt = 1'b0;
          if (r_line_cnt != 8'd0) w_state_nxt = ST_CR;
        end else if (bus.i_word_valid) begin
          w_word_q_nxt = bus.i_word;
          w_state_nxt  = ST_CONV;
        end
      end
      ST_CONV:  w_state_nxt = ST_SEND3;
      ST_SEND3: if (w_hs) w_state_nxt = ST_SEND2;
      ST_SEND2: if (w_hs) w_state_nxt = ST_SEND1;
      ST_SEND1: if (w_hs) w_state_nxt = ST_SEND0;
      ST_SEND0: begin
        if (w_hs) begin
          if (r_line_cnt == LAST_IDX) begin
            w_state_nxt = ST_CR;
          end else begin
            w_state_nxt    = ST_SEP;
            w_line_cnt_nxt = r_line_cnt + 8'd1;
          end
        end
      end
      ST_SEP: if (w_hs) w_state_nxt = ST_IDLE;
      ST_CR:  if (w_hs) w_state_nxt = ST_LF;
      ST_LF: begin
        if (w_hs) begin
          w_state_nxt    = ST_IDLE;
          w_line_cnt_nxt = 8'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: word_q is reset as well, so the converter output is defined from the first cycle.
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      r_state      <= ST_IDLE;
      r_line_cnt   <= 8'd0;
      r_flush_pend <= 1'b0;
      r_word_q     <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_line_cnt   <= w_line_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_word_q     <= w_word_q_nxt;
    end
  end

  assign bus.o_char       = w_char;
  assign bus.o_char_valid = w_char_valid;
  assign bus.o_word_ready = (r_state == ST_IDLE) && !r_flush_pend;
  assign bus.o_busy       = (r_state != ST_IDLE) || r_flush_pend;

endmodule

// File: tb/tb_hex_word_streamer.sv
// Self-checking bench for hex_word_streamer. Three instances share clock,
// reset, word, flush and ready: WORDS_PER_LINE = 8, 2 and 1.
module tb_hex_word_streamer;

  localparam int    N    = 3;
  localparam string CRLF = "\015\012";

  function automatic int wpl_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] t_word;
  logic        t_flush;
  logic        t_ready;
  logic        t_valid [N];

  logic [7:0]  o_char       [N];
  logic        o_char_valid [N];
  logic        o_word_ready [N];
  logic        o_busy       [N];

  hex_word_streamer_if bus0 ();
  hex_word_streamer_if bus1 ();
  hex_word_streamer_if bus2 ();

  assign bus0.i_word = t_word;   assign bus0.i_word_valid = t_valid[0];
  assign bus0.i_flush = t_flush; assign bus0.i_char_ready = t_ready;
  assign bus1.i_word = t_word;   assign bus1.i_word_valid = t_valid[1];
  assign bus1.i_flush = t_flush; assign bus1.i_char_ready = t_ready;
  assign bus2.i_word = t_word;   assign bus2.i_word_valid = t_valid[2];
  assign bus2.i_flush = t_flush; assign bus2.i_char_ready = t_ready;

  assign o_char[0] = bus0.o_char; assign o_char_valid[0] = bus0.o_char_valid;
  assign o_word_ready[0] = bus0.o_word_ready; assign o_busy[0] = bus0.o_busy;
  assign o_char[1] = bus1.o_char; assign o_char_valid[1] = bus1.o_char_valid;
  assign o_word_ready[1] = bus1.o_word_ready; assign o_busy[1] = bus1.o_busy;
  assign o_char[2] = bus2.o_char; assign o_char_valid[2] = bus2.o_char_valid;
  assign o_word_ready[2] = bus2.o_word_ready; assign o_busy[2] = bus2.o_busy;

  hex_word_streamer u_dut0 (.I_CLK(clk), .I_RSTF(rst_n), .bus(bus0));
  hex_word_streamer #(.WORDS_PER_LINE(2)) u_dut1 (.I_CLK(clk), .I_RSTF(rst_n), .bus(bus1));
  hex_word_streamer #(.WORDS_PER_LINE(1)) u_dut2 (.I_CLK(clk), .I_RSTF(rst_n), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Observed characters and producer-side events (accepted words, flushes).
  typedef struct packed { logic is_flush; logic [15:0] word; } ev_t;
  logic [7:0] got_q [N][$];
  ev_t        ev_q  [N][$];

  function automatic logic [7:0] got_at(input int k, input int i);
    if (i < got_q[k].size()) return got_q[k][i];
    return 8'hxx;
  endfunction

  // Ready pattern: 0 = always ready, 1 = toggling, 2 = random stalls.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       t_ready = 1'b1;
      1:       t_ready = ~t_ready;
      default: t_ready = ($urandom_range(0, 9) < 6);
    endcase
  end

  // Monitors sample at the falling edge: a handshake seen here completes on the next rising edge.
  for (genvar k = 0; k < N; k++) begin : g_mon
    logic       prev_hold;
    logic [7:0] prev_char;
    always @(negedge clk) begin
      if (!rst_n) begin
        prev_hold <= 1'b0;
      end else begin
        if (prev_hold) begin
          check($sformatf("hold_valid%0d", k), o_char_valid[k], 1'b1);
          check($sformatf("hold_char%0d", k), o_char[k], prev_char);
        end
        if (o_char_valid[k] && t_ready) got_q[k].push_back(o_char[k]);
        if (t_valid[k] && o_word_ready[k]) ev_q[k].push_back({1'b0, t_word});
        if (t_flush) ev_q[k].push_back({1'b1, 16'h0000});
        prev_hold <= o_char_valid[k] && !t_ready;
        prev_char <= o_char[k];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    t_flush = 1'b0;
    foreach (t_valid[k]) t_valid[k] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      got_q[k].delete();
      ev_q[k].delete();
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_word(input int k, input logic [15:0] w);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    t_word = w;
    t_valid[k] = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = o_word_ready[k];
    end
    @(posedge clk);
    #1 t_valid[k] = 1'b0;
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1 t_flush = 1'b1;
    @(posedge clk);
    #1 t_flush = 1'b0;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int c = 0; c < 600 && !idle; c++) begin
      @(negedge clk);
      idle = 1'b1;
      for (int k = 0; k < N; k++) if (o_busy[k] || o_char_valid[k]) idle = 1'b0;
    end
    if (!idle) check("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_str(input int k, input string name, input string exp);
    check({name, "_len"}, got_q[k].size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check($sformatf("%s_c%0d", name, i), got_at(k, i), exp[i]);
    got_q[k].delete();
  endtask

  // Reference model: the text each instance must emit for its event history.
  task automatic model_compare(input int k);
    logic [7:0] exp_q [$];
    int cnt = 0;
    int bad = 0;
    string s;
    foreach (ev_q[k][i]) begin
      if (ev_q[k][i].is_flush) begin
        if (cnt != 0) begin
          exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
          cnt = 0;
        end
      end else begin
        s = $sformatf("%04h", ev_q[k][i].word);
        for (int n = 0; n < 4; n++) exp_q.push_back(s[n]);
        if (cnt + 1 == wpl_of(k)) begin
          exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
          cnt = 0;
        end else begin
          exp_q.push_back(8'h20);
          cnt++;
        end
      end
    end
    check($sformatf("rand%0d_len", k), got_q[k].size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && bad < 8; i++) begin
      if (got_at(k, i) !== exp_q[i]) bad++;
      check($sformatf("rand%0d_c%0d", k, i), got_at(k, i), exp_q[i]);
    end
    got_q[k].delete();
    ev_q[k].delete();
  endtask

  typedef struct packed { logic [15:0] word; logic [31:0] hex; } vec_t;

  initial begin
    vec_t vecs [8];
    vecs[0] = '{16'h0000, "0000"};
    vecs[1] = '{16'hFFFF, "ffff"};
    vecs[2] = '{16'h09AF, "09af"};
    vecs[3] = '{16'hBEEF, "beef"};
    vecs[4] = '{16'h1234, "1234"};
    vecs[5] = '{16'hA5F0, "a5f0"};
    vecs[6] = '{16'h7E81, "7e81"};
    vecs[7] = '{16'hCAFE, "cafe"};

    rst_n = 1'b0;
    t_word = 16'h0000;
    t_flush = 1'b0;
    t_ready = 1'b1;
    foreach (t_valid[k]) t_valid[k] = 1'b0;

    // Reset values
    #12;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_valid%0d", k), o_char_valid[k], 1'b0);
      check($sformatf("rst_char%0d", k),  o_char[k],       8'h00);
      check($sformatf("rst_busy%0d", k),  o_busy[k],       1'b0);
      check($sformatf("rst_ready%0d", k), o_word_ready[k], 1'b1);
    end
    do_reset();

    // Table: one full line of 8 words on the default instance
    for (int i = 0; i < 8; i++) begin
      send_word(0, vecs[i].word);
      drain();
      check($sformatf("tbl%0d_len", i), got_q[0].size(), (i == 7) ? 6 : 5);
      for (int n = 0; n < 4; n++)
        check($sformatf("tbl%0d_c%0d", i, n), got_at(0, n), vecs[i].hex[8*(3-n) +: 8]);
      if (i == 7) begin
        check("tbl_cr", got_at(0, 4), 8'h0D);
        check("tbl_lf", got_at(0, 5), 8'h0A);
      end else begin
        check($sformatf("tbl%0d_sep", i), got_at(0, 4), 8'h20);
      end
      got_q[0].delete();
    end

    // Single word timing
    do_reset();
    @(posedge clk);
    #1;
    t_word = 16'hBEEF;
    t_valid[0] = 1'b1;
    @(negedge clk);
    check("beef_ready_at_accept", o_word_ready[0], 1'b1);
    @(posedge clk);
    #1 t_valid[0] = 1'b0;
    @(negedge clk);
    check("beef_conv_valid", o_char_valid[0], 1'b0);
    @(negedge clk);
    check("beef_first_valid", o_char_valid[0], 1'b1);
    check("beef_first_char", o_char[0], 8'h62);
    repeat (4) @(negedge clk);
    check("beef_ready_e5", o_word_ready[0], 1'b0);
    @(negedge clk);
    check("beef_ready_e6", o_word_ready[0], 1'b1);
    check("beef_busy_e6", o_busy[0], 1'b0);
    drain();
    expect_str(0, "beef", "beef ");

    // Automatic line break, two words per line; next word starts a new line
    do_reset();
    send_word(1, 16'h0001); drain();
    send_word(1, 16'hA5F0); drain();
    expect_str(1, "wpl2", {"0001 a5f0", CRLF});
    send_word(1, 16'h0000); drain();
    expect_str(1, "wpl2_next", "0000 ");

    // One word per line, then a flush on an empty line
    send_word(2, 16'h1234); drain();
    send_word(2, 16'hFFFF); drain();
    expect_str(2, "wpl1", {"1234", CRLF, "ffff", CRLF});
    pulse_flush(); drain();
    expect_str(2, "wpl1_flush", "");

    // Backpressure: toggling ready, then random stalls
    do_reset();
    rdy_mode = 1;
    send_word(0, 16'h1234); drain();
    expect_str(0, "bp_toggle", "1234 ");
    rdy_mode = 2;
    send_word(0, 16'h1234); drain();
    expect_str(0, "bp_random", "1234 ");
    rdy_mode = 0;
    @(posedge clk);

    // Flush of a partial line, then of an empty one
    do_reset();
    send_word(0, 16'h00FF); drain();
    pulse_flush();
    @(negedge clk);
    check("flush_cr_valid", o_char_valid[0], 1'b1);
    check("flush_cr_char", o_char[0], 8'h0D);
    drain();
    expect_str(0, "flush", {"00ff ", CRLF});
    pulse_flush();
    @(negedge clk);
    check("flush_empty_valid", o_char_valid[0], 1'b0);
    @(negedge clk);
    check("flush_empty_busy", o_busy[0], 1'b0);
    drain();
    expect_str(0, "flush_empty", "");

    // Flush pulsed during SEND2
    do_reset();
    send_word(0, 16'h5A3C);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("send2_char", o_char[0], 8'h61);
    t_flush = 1'b1;
    @(posedge clk);
    #1 t_flush = 1'b0;
    drain();
    expect_str(0, "flush_send2", {"5a3c ", CRLF});

    // Flush and word together in IDLE on an empty line
    do_reset();
    @(posedge clk);
    #1;
    t_word = 16'hCAFE;
    t_valid[0] = 1'b1;
    t_flush = 1'b1;
    @(negedge clk);
    check("simul_ready", o_word_ready[0], 1'b1);
    @(posedge clk);
    #1;
    t_valid[0] = 1'b0;
    t_flush = 1'b0;
    drain();
    expect_str(0, "simul", {"cafe ", CRLF});

    // Reset mid-word (SEND1) on the two-words-per-line instance
    do_reset();
    send_word(1, 16'h1111); drain();
    expect_str(1, "pre_rst", "1111 ");
    send_word(1, 16'h9876);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("send1_char", o_char[1], 8'h37);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", o_char_valid[1], 1'b0);
    check("midrst_char",  o_char[1],       8'h00);
    check("midrst_busy",  o_busy[1],       1'b0);
    check("midrst_ready", o_word_ready[1], 1'b1);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      got_q[k].delete();
      ev_q[k].delete();
    end
    #2 rst_n = 1'b1;
    send_word(1, 16'h0ABC); drain();
    expect_str(1, "post_rst", "0abc ");

    // Random traffic on all three instances against the model
    do_reset();
    rdy_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      t_word = 16'($urandom);
      t_flush = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < N; k++) t_valid[k] = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #1;
    t_flush = 1'b0;
    foreach (t_valid[k]) t_valid[k] = 1'b0;
    drain();
    for (int k = 0; k < N; k++) model_compare(k);
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
